cu_imm_fsm: RTL and testbench
=============================

CU_IMM_FSM -- requirements
Module: cu_imm_fsm

Interface
REQ-001 Parameter DATA_W, default 64, datapath width in bits; legal values are 32 and 64.
REQ-002 Parameter CUL, default 36, MSB index of the control word.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  IR valid; requests execution of one immediate-class instruction.
REQ-006 IR  input  32  instruction word, sampled only on accepted start.
REQ-007 status  input  4  NZCV flags; accepted but do not affect decode.
REQ-008 controlWord  output  CUL+1  {FS[4:0], SA[4:0], SB[4:0], DA[4:0], w_reg, C0, mem_cs[1:0], B_Sel, mem_write_en, IR_load, status_load, size[1:0], add_tri_sel, data_tri_sel[1:0], PC_sel, PC_FS[1:0]}.
REQ-009 k_mux  output  3  constant-source select.
REQ-010 shamt  output  6  shift amount.
REQ-011 mov_hw  output  2  MOV halfword position.
REQ-012 busy  output  1  high in any non-IDLE state.
REQ-013 done  output  1  one-cycle pulse in the final execute cycle.
REQ-014 illegal  output  1  one-cycle pulse, coincident with done, for an undecodable or width-illegal IR.

Function
REQ-015 States: IDLE, EX0, EX1.
- IDLE + start -> EX0, and latch IR.
- EX0 -> EX1 if MOVK, else -> IDLE.
- EX1 -> IDLE.
REQ-016 start is ignored while busy; the latched IR is unchanged.
REQ-017 Decode uses the latched IR with op = IR[30:29]:
- LOGIC: IR[28:22]=1001000; op 0/1/2/3 = ANDI/ORRI/EORI/ANDIS.
- MATH: IR[28:24]=10001; op 0/1/2/3 = ADDI/ADDIS/SUBI/SUBIS.
- MOV: IR[28:23]=100101; op 2 = MOVZ, op 3 = MOVK.
- SHIFT: IR[28:22]=1001101; IR[21]=1 is LSL, IR[21]=0 is LSR.
- Anything else is illegal.
REQ-018 FS encoding:
- ADD 01000 for ADDI/ADDIS.
- SUB 01001 for SUBI/SUBIS.
- AND 00000 for ANDI/ANDIS.
- AND-NOT-B 00001 for MOVK in EX0.
- ORR 00100 for MOVZ, MOVK in EX1, and ORRI.
- XOR 01100 for EORI.
- LSR 10100.
- LSL 10000.
REQ-019 Field sources: SA=IR[9:5], SB=IR[20:16], DA=IR[4:0].
REQ-020 Fixed control bits: B_Sel=1; mem_cs, mem_write_en, IR_load, size, add_tri_sel, data_tri_sel and PC_sel all 0.
REQ-021 Computed control bits:
- C0=1 for SUBI/SUBIS.
- status_load=1 for ADDIS/SUBIS/ANDIS, only in the final execute cycle.
REQ-022 PC_FS:
- 01 in the final execute cycle.
- 00 in MOVK EX0.
- 00 in IDLE.
REQ-023 w_reg=1 in EX0 and EX1 for legal instructions; 0 in IDLE and for illegal instructions.
REQ-024 k_mux:
- SHIFT: 110.
- MOATH and LOGIC: 000.
- MOVK EX0: 101 (mask).
- Other MOV: 100.
REQ-025 mov_hw=IR[22:21].
REQ-026 shamt:
- MOV: {mov_hw, 4'b0000}, i.e. 0/16/32/48.
- Otherwise: IR[15:10].
REQ-027 When DATA_W=32, MOV with mov_hw[1]=1 and SHIFT with IR[15]=1 are illegal.
REQ-028 Illegal instruction handling: one EX0 cycle with w_reg=0, status_load=0, PC_FS=01, illegal=1 and done=1.
REQ-029 In IDLE, controlWord is all zero and k_mux, shamt, mov_hw, done and illegal are 0.

Reset
REQ-030 reset_n low asynchronously forces IDLE, clears the latched IR, and forces every output to its IDLE value; this holds mid-instruction, including between MOVK EX0 and EX1.
REQ-031 The first start is accepted on the first rising clock edge after reset_n deasserts.

Configuration
REQ-032 Macro CU_IMM_SHIFT_EN:
- Defined: LSL/LSR are decoded per REQ-017/018.
- Undefined: the SHIFT pattern is treated as illegal per REQ-028 and the LSL/LSR FS codes are never driven.

Structure
REQ-033 Package cu_pkg holds:
- the state enum;
- the FS code localparams;
- the k_mux code localparams;
- the opcode pattern constants;
- the controlWord field offsets.
REQ-034 One sub-module, cu_imm_decode: purely combinational, mapping latched IR + state to the class/op flags.

Verification
REQ-035 ADDIS IR=0xB1000C41, DATA_W=64, start one cycle -> EX0 next cycle:
- FS=01000, SA=2, SB=0, DA=1;
- status_load=1, PC_FS=01, k_mux=000;
- done=1, then IDLE.
REQ-036 MOVK with hw=1 (IR=0xF2A00020) -> EX0 then EX1:
- EX0: FS=00001, k_mux=101, PC_FS=00, shamt=16.
- EX1: FS=00100, k_mux=100, PC_FS=01, done=1.
REQ-037 Undefined opcode IR=0x00000000 -> EX0 only: illegal=1, done=1, w_reg=0, PC_FS=01.
REQ-038 DATA_W=32, MOVZ with hw=2 -> illegal=1; same IR with DATA_W=64 -> shamt=32, w_reg=1.
REQ-039 start pulsed during MOVK EX0 with a different IR -> ignored; EX1 still shows MOVK values and busy stays 1 through EX1.
REQ-040 reset_n asserted during MOVK EX0 -> all outputs go to IDLE values immediately; after release, a new ADDI start executes normally.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the immediate-class control unit.
//   state_t      : FSM states (IDLE, EX0, EX1)
//   FS_*         : ALU function-select codes
//   KM_*         : constant-source select codes driven on k_mux
//   PAT_*        : instruction-class opcode patterns
//   CW_*         : bit offsets of the fields inside controlWord
// controlWord packs 36 bits of fields; the top bit (36 with the default CUL)
// is a spare and stays zero.
package cu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EX0  = 2'b01,
    ST_EX1  = 2'b10
  } state_t;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ANDNB = 5'b00001;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_LSL   = 5'b10000;
  localparam logic [4:0] FS_LSR   = 5'b10100;

  localparam logic [2:0] KM_IMM   = 3'b000;
  localparam logic [2:0] KM_MOV   = 3'b100;
  localparam logic [2:0] KM_MASK  = 3'b101;
  localparam logic [2:0] KM_SHIFT = 3'b110;

  localparam logic [6:0] PAT_LOGIC = 7'b1001000;
  localparam logic [4:0] PAT_MATH  = 5'b10001;
  localparam logic [5:0] PAT_MOV   = 6'b100101;
  localparam logic [6:0] PAT_SHIFT = 7'b1001101;
  localparam logic [1:0] OP_MOVK   = 2'b11;

  localparam logic [1:0] PCFS_HOLD = 2'b00;
  localparam logic [1:0] PCFS_INC  = 2'b01;

  localparam int CW_PCFS_LSB  = 0;
  localparam int CW_STLOAD    = 8;
  localparam int CW_BSEL      = 11;
  localparam int CW_C0        = 14;
  localparam int CW_WREG      = 15;
  localparam int CW_DA_LSB    = 16;
  localparam int CW_SB_LSB    = 21;
  localparam int CW_SA_LSB    = 26;
  localparam int CW_FS_LSB    = 31;

endpackage

// File: rtl/cu_imm_decode.sv
// Combinational instruction-class decoder for the immediate control unit.
// Ports:
//   ir_hi       [30:21] of the instruction (op + class pattern + hw/shift dir)
//   ir_b15      IR[15], top bit of the shift amount (width check)
//   state       FSM state the flags are evaluated for
//   is_logic / is_math / is_mov / is_shift : class hits
//   shift_left  LSL (1) vs LSR (0)
//   op          IR[30:29]
//   legal       instruction decodes and fits DATA_W
//   movk_ex0    first cycle of a legal MOVK (mask phase)
//   final_cycle last execute cycle of the instruction in this state
// Macro CU_IMM_SHIFT_EN enables LSL/LSR decode; without it the shift pattern
// falls through as illegal.
module cu_imm_decode
  import cu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [30:21] ir_hi,
  input  logic         ir_b15,
  input  state_t       state,
  output logic         is_logic,
  output logic         is_math,
  output logic         is_mov,
  output logic         is_shift,
  output logic         shift_left,
  output logic [1:0]   op,
  output logic         legal,
  output logic         movk_ex0,
  output logic         final_cycle
);

  logic width_bad_s;
  logic movk_s;

  // Class match, width legality and cycle-position flags.
  always_comb begin
    op         = ir_hi[30:29];
    shift_left = ir_hi[21];
    is_logic   = (ir_hi[28:22] == PAT_LOGIC);
    is_math    = (ir_hi[28:24] == PAT_MATH);
    // Only MOVZ (op 2) and MOVK (op 3) exist in the MOV group.
    is_mov     = (ir_hi[28:23] == PAT_MOV) && ir_hi[30];
`ifdef CU_IMM_SHIFT_EN
    is_shift   = (ir_hi[28:22] == PAT_SHIFT);
`else
    is_shift   = 1'b0;
`endif
    // A 32-bit datapath has no upper halfwords and no shifts of 32 or more.
    width_bad_s = (DATA_W == 32) && ((is_mov && ir_hi[22]) || (is_shift && ir_b15));
    legal       = (is_logic || is_math || is_mov || is_shift) && !width_bad_s;
    movk_s      = legal && is_mov && (op == OP_MOVK);
    movk_ex0    = movk_s && (state == ST_EX0);
    case (state)
      ST_EX0:  final_cycle = !movk_s;
      ST_EX1:  final_cycle = 1'b1;
      default: final_cycle = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_imm_fsm.sv
// Control unit for immediate-class instructions (logic, math, MOVZ/MOVK,
// optional LSL/LSR). IDLE accepts start and latches IR; EX0 executes, and
// MOVK takes a second cycle EX1 (mask, then OR-in).
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   start, IR       instruction request and word (sampled in IDLE only)
//   status          NZCV flags, not used by this decoder
//   controlWord     {FS,SA,SB,DA,w_reg,C0,mem_cs,B_Sel,mem_write_en,IR_load,
//                    status_load,size,add_tri_sel,data_tri_sel,PC_sel,PC_FS}
//   k_mux, shamt, mov_hw  constant-source select, shift amount, MOV halfword
//   busy, done, illegal   non-IDLE, final execute cycle, undecodable IR
// Macro CU_IMM_SHIFT_EN enables LSL/LSR support.
// All outputs are registers loaded from the decode of the next state and
// next latched IR, so they line up with the state they describe and clear
// asynchronously on reset.
module cu_imm_fsm
  import cu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CUL    = 36
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  IR,
  input  logic [3:0]   status,
  output logic [CUL:0] controlWord,
  output logic [2:0]   k_mux,
  output logic [5:0]   shamt,
  output logic [1:0]   mov_hw,
  output logic         busy,
  output logic         done,
  output logic         illegal
);

  state_t        state_r, state_next_s;
  logic [30:0]   ir_r, ir_next_s;
  logic [CUL:0]  cw_r, cw_s;
  logic [2:0]    k_mux_r, k_mux_s;
  logic [5:0]    shamt_r, shamt_s;
  logic [1:0]    mov_hw_r, mov_hw_s;
  logic          busy_r, busy_s, done_r, done_s, illegal_r, illegal_s;
  logic [4:0]    fs_s;

  logic          d_logic_s, d_math_s, d_mov_s, d_shift_s, d_left_s;
  logic          d_legal_s, d_movk_ex0_s, d_final_s;
  logic [1:0]    d_op_s;

  // Flags and IR[31] are not part of immediate decode.
  logic unused_s;
  assign unused_s = ^{status, IR[31]};

  cu_imm_decode #(.DATA_W(DATA_W)) u_decode (
    .ir_hi       (ir_next_s[30:21]),
    .ir_b15      (ir_next_s[15]),
    .state       (state_next_s),
    .is_logic    (d_logic_s),
    .is_math     (d_math_s),
    .is_mov      (d_mov_s),
    .is_shift    (d_shift_s),
    .shift_left  (d_left_s),
    .op          (d_op_s),
    .legal       (d_legal_s),
    .movk_ex0    (d_movk_ex0_s),
    .final_cycle (d_final_s)
  );

  // Next state and IR latch; done_r marks whether EX0 is the last cycle.
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = ir_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_EX0;
          ir_next_s    = IR[30:0];
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EX0: begin
        if (done_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_EX1;
        end
      end
      ST_EX1:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode for the upcoming state.
  always_comb begin
    cw_s      = '0;
    fs_s      = FS_AND;
    k_mux_s   = KM_IMM;
    shamt_s   = 6'd0;
    mov_hw_s  = 2'b00;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    illegal_s = 1'b0;
    if (state_next_s != ST_IDLE) begin
      busy_s    = 1'b1;
      done_s    = d_final_s;
      illegal_s = !d_legal_s;
      mov_hw_s  = ir_next_s[22:21];
      if (d_mov_s) begin
        shamt_s = {ir_next_s[22:21], 4'b0000};
      end else begin
        shamt_s = ir_next_s[15:10];
      end
      cw_s[CW_PCFS_LSB +: 2] = d_final_s ? PCFS_INC : PCFS_HOLD;
      if (d_legal_s) begin
        if (d_math_s) begin
          fs_s = d_op_s[1] ? FS_SUB : FS_ADD;
        end else if (d_logic_s) begin
          case (d_op_s)
            2'b01:   fs_s = FS_ORR;
            2'b10:   fs_s = FS_XOR;
            default: fs_s = FS_AND;
          endcase
        end else if (d_mov_s) begin
          fs_s    = d_movk_ex0_s ? FS_ANDNB : FS_ORR;
          k_mux_s = d_movk_ex0_s ? KM_MASK : KM_MOV;
        end else begin
          fs_s    = d_left_s ? FS_LSL : FS_LSR;
          k_mux_s = KM_SHIFT;
        end
        cw_s[CW_FS_LSB +: 5] = fs_s;
        cw_s[CW_SA_LSB +: 5] = ir_next_s[9:5];
        cw_s[CW_SB_LSB +: 5] = ir_next_s[20:16];
        cw_s[CW_DA_LSB +: 5] = ir_next_s[4:0];
        cw_s[CW_WREG]        = 1'b1;
        cw_s[CW_BSEL]        = 1'b1;
        cw_s[CW_C0]          = d_math_s && d_op_s[1];
        // Flag-setting forms: ADDIS/SUBIS (math op odd) and ANDIS.
        cw_s[CW_STLOAD]      = d_final_s &&
                               ((d_math_s && d_op_s[0]) || (d_logic_s && (d_op_s == 2'b11)));
      end else begin
        fs_s = FS_AND;
      end
    end else begin
      busy_s = 1'b0;
    end
  end

  // State, latched IR and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      ir_r      <= 31'd0;
      cw_r      <= '0;
      k_mux_r   <= 3'b000;
      shamt_r   <= 6'd0;
      mov_hw_r  <= 2'b00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      ir_r      <= ir_next_s;
      cw_r      <= cw_s;
      k_mux_r   <= k_mux_s;
      shamt_r   <= shamt_s;
      mov_hw_r  <= mov_hw_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      illegal_r <= illegal_s;
    end
  end

  assign controlWord = cw_r;
  assign k_mux       = k_mux_r;
  assign shamt       = shamt_r;
  assign mov_hw      = mov_hw_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign illegal     = illegal_r;

endmodule

// File: tb/tb_cu_imm_fsm.sv
// Directed bench for cu_imm_fsm: a 64-bit instance and a 32-bit instance
// share the same stimulus. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_cu_imm_fsm;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] IR = 32'd0;
  logic [3:0]  status = 4'd0;

  logic [36:0] cw, cw32;
  logic [2:0]  k_mux, k_mux32;
  logic [5:0]  shamt, shamt32;
  logic [1:0]  mov_hw, mov_hw32;
  logic        busy, busy32, done, done32, illegal, illegal32;

  int checks = 0;
  int errors = 0;

  wire [4:0] fs    = cw[35:31];
  wire [4:0] sa    = cw[30:26];
  wire [4:0] sb    = cw[25:21];
  wire [4:0] da    = cw[20:16];
  wire       w_reg = cw[15];
  wire       c0    = cw[14];
  wire       bsel  = cw[11];
  wire       stl   = cw[8];
  wire [1:0] pcfs  = cw[1:0];
  wire [11:0] fixed0 = {cw[36], cw[13:12], cw[10:9], cw[7:2]};

  cu_imm_fsm #(.DATA_W(64), .CUL(36)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .IR(IR), .status(status),
    .controlWord(cw), .k_mux(k_mux), .shamt(shamt), .mov_hw(mov_hw),
    .busy(busy), .done(done), .illegal(illegal)
  );

  cu_imm_fsm #(.DATA_W(32), .CUL(36)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(start), .IR(IR), .status(status),
    .controlWord(cw32), .k_mux(k_mux32), .shamt(shamt32), .mov_hw(mov_hw32),
    .busy(busy32), .done(done32), .illegal(illegal32)
  );

  always #5 clock = ~clock;

  // Pulse start for one cycle; returns at the falling edge where EX0 is visible.
  task automatic issue(input logic [31:0] ir_v);
    @(negedge clock);
    start = 1'b1;
    IR    = ir_v;
    @(negedge clock);
    start = 1'b0;
    IR    = 32'd0;
  endtask

  task automatic test_reset;
    status = 4'b1111;
    repeat (3) @(negedge clock);
    checks++; if (cw !== 37'd0) begin errors++; $display("FAIL reset_cw got %h exp 0", cw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({k_mux, shamt, mov_hw, done, illegal} !== 13'd0) begin errors++; $display("FAIL reset_misc got %h exp 0", {k_mux, shamt, mov_hw, done, illegal}); end
  endtask

  // First start right at reset release, ADDIS 0xB1000C41.
  task automatic test_addis_first_start;
    @(negedge clock);
    reset_n = 1'b1;
    start   = 1'b1;
    IR      = 32'hB100_0C41;
    @(negedge clock);
    start = 1'b0;
    IR    = 32'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addis_busy got %b exp 1", busy); end
    checks++; if (fs !== 5'b01000) begin errors++; $display("FAIL addis_fs got %b exp 01000", fs); end
    checks++; if ({sa, sb, da} !== {5'd2, 5'd0, 5'd1}) begin errors++; $display("FAIL addis_regs got %h exp %h", {sa, sb, da}, {5'd2, 5'd0, 5'd1}); end
    checks++; if (stl !== 1'b1) begin errors++; $display("FAIL addis_status_load got %b exp 1", stl); end
    checks++; if (pcfs !== 2'b01) begin errors++; $display("FAIL addis_pcfs got %b exp 01", pcfs); end
    checks++; if (k_mux !== 3'b000) begin errors++; $display("FAIL addis_kmux got %b exp 000", k_mux); end
    checks++; if ({done, illegal, w_reg, c0, bsel} !== 5'b10101) begin errors++; $display("FAIL addis_bits got %b exp 10101", {done, illegal, w_reg, c0, bsel}); end
    checks++; if (shamt !== 6'd3) begin errors++; $display("FAIL addis_shamt got %0d exp 3", shamt); end
    checks++; if (fixed0 !== 12'd0) begin errors++; $display("FAIL addis_fixed0 got %h exp 0", fixed0); end
    @(negedge clock);
    checks++; if ({busy, done} !== 2'b00 || cw !== 37'd0) begin errors++; $display("FAIL addis_idle got busy=%b done=%b cw=%h exp 0", busy, done, cw); end
  endtask

  task automatic test_movk;
    issue(32'hF2A0_0020);
    checks++; if (fs !== 5'b00001) begin errors++; $display("FAIL movk0_fs got %b exp 00001", fs); end
    checks++; if (k_mux !== 3'b101) begin errors++; $display("FAIL movk0_kmux got %b exp 101", k_mux); end
    checks++; if (pcfs !== 2'b00) begin errors++; $display("FAIL movk0_pcfs got %b exp 00", pcfs); end
    checks++; if ({shamt, mov_hw} !== {6'd16, 2'b01}) begin errors++; $display("FAIL movk0_shamt got %0d/%0d exp 16/1", shamt, mov_hw); end
    checks++; if ({busy, done, w_reg, stl, sa, da} !== {4'b1010, 5'd1, 5'd0}) begin errors++; $display("FAIL movk0_bits got %h exp %h", {busy, done, w_reg, stl, sa, da}, {4'b1010, 5'd1, 5'd0}); end
    @(negedge clock);
    checks++; if (fs !== 5'b00100) begin errors++; $display("FAIL movk1_fs got %b exp 00100", fs); end
    checks++; if (k_mux !== 3'b100) begin errors++; $display("FAIL movk1_kmux got %b exp 100", k_mux); end
    checks++; if ({pcfs, done, busy, w_reg} !== 5'b01111) begin errors++; $display("FAIL movk1_bits got %b exp 01111", {pcfs, done, busy, w_reg}); end
    checks++; if (shamt !== 6'd16) begin errors++; $display("FAIL movk1_shamt got %0d exp 16", shamt); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL movk_idle got %b exp 0", busy); end
  endtask

  task automatic test_illegal;
    issue(32'h0000_0000);
    checks++; if ({illegal, done, w_reg, stl, busy} !== 5'b11001) begin errors++; $display("FAIL illegal_bits got %b exp 11001", {illegal, done, w_reg, stl, busy}); end
    checks++; if (pcfs !== 2'b01) begin errors++; $display("FAIL illegal_pcfs got %b exp 01", pcfs); end
    @(negedge clock);
    checks++; if ({busy, illegal, done} !== 3'b000) begin errors++; $display("FAIL illegal_idle got %b exp 000", {busy, illegal, done}); end
  endtask

  // MOVZ hw=2: legal on 64-bit, illegal on 32-bit.
  task automatic test_width;
    issue(32'hD2C0_0003);
    checks++; if ({illegal, w_reg, done} !== 3'b011) begin errors++; $display("FAIL movz64_bits got %b exp 011", {illegal, w_reg, done}); end
    checks++; if (shamt !== 6'd32) begin errors++; $display("FAIL movz64_shamt got %0d exp 32", shamt); end
    checks++; if ({fs, k_mux, da} !== {5'b00100, 3'b100, 5'd3}) begin errors++; $display("FAIL movz64_cw got %h exp %h", {fs, k_mux, da}, {5'b00100, 3'b100, 5'd3}); end
    checks++; if ({illegal32, cw32[15], done32, cw32[1:0]} !== 5'b10101) begin errors++; $display("FAIL movz32_bits got %b exp 10101", {illegal32, cw32[15], done32, cw32[1:0]}); end
    @(negedge clock);
  endtask

  task automatic test_logic_math;
    logic [31:0] ir_t  [5] = '{32'hD200_0000, 32'hF200_0000, 32'hB200_0000, 32'hD100_0000, 32'hF100_0000};
    logic [4:0]  fs_t  [5] = '{5'b01100, 5'b00000, 5'b00100, 5'b01001, 5'b01001};
    logic        c0_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        stl_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ir_t[i]);
      checks++; if (fs !== fs_t[i]) begin errors++; $display("FAIL lm%0d_fs got %b exp %b", i, fs, fs_t[i]); end
      checks++; if ({c0, stl} !== {c0_t[i], stl_t[i]}) begin errors++; $display("FAIL lm%0d_c0_stl got %b exp %b", i, {c0, stl}, {c0_t[i], stl_t[i]}); end
      checks++; if ({k_mux, done, illegal} !== 5'b00010) begin errors++; $display("FAIL lm%0d_misc got %b exp 00010", i, {k_mux, done, illegal}); end
      @(negedge clock);
    end
  endtask

  task automatic test_shift;
    issue(32'hD360_1400);
`ifdef CU_IMM_SHIFT_EN
    checks++; if ({fs, k_mux, shamt} !== {5'b10000, 3'b110, 6'd5}) begin errors++; $display("FAIL lsl_cw got %h exp %h", {fs, k_mux, shamt}, {5'b10000, 3'b110, 6'd5}); end
    checks++; if ({illegal, w_reg, done} !== 3'b011) begin errors++; $display("FAIL lsl_bits got %b exp 011", {illegal, w_reg, done}); end
    @(negedge clock);
    issue(32'hD340_1400);
    checks++; if (fs !== 5'b10100) begin errors++; $display("FAIL lsr_fs got %b exp 10100", fs); end
    @(negedge clock);
    issue(32'hD360_8000);
    checks++; if ({illegal, shamt, illegal32} !== {1'b0, 6'd32, 1'b1}) begin errors++; $display("FAIL shift_width got %b exp 0_100000_1", {illegal, shamt, illegal32}); end
`else
    checks++; if ({illegal, w_reg, done, pcfs} !== 5'b10101) begin errors++; $display("FAIL shift_off_bits got %b exp 10101", {illegal, w_reg, done, pcfs}); end
    checks++; if (fs !== 5'b00000) begin errors++; $display("FAIL shift_off_fs got %b exp 00000", fs); end
`endif
    @(negedge clock);
  endtask

  // start during MOVK EX0 with another IR must be ignored.
  task automatic test_back_to_back;
    issue(32'hF2A0_0020);
    start = 1'b1;
    IR    = 32'hB100_0C41;
    @(negedge clock);
    start = 1'b0;
    IR    = 32'd0;
    checks++; if ({fs, k_mux} !== {5'b00100, 3'b100}) begin errors++; $display("FAIL b2b_ex1_fs got %h exp %h", {fs, k_mux}, {5'b00100, 3'b100}); end
    checks++; if ({busy, done, stl, sa, da} !== {3'b110, 5'd1, 5'd0}) begin errors++; $display("FAIL b2b_ex1_bits got %h exp %h", {busy, done, stl, sa, da}, {3'b110, 5'd1, 5'd0}); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    issue(32'hF2A0_0020);
    reset_n = 1'b0;
    #1;
    checks++; if (cw !== 37'd0) begin errors++; $display("FAIL rstmid_cw got %h exp 0", cw); end
    checks++; if ({busy, done, illegal, k_mux, shamt, mov_hw} !== 14'd0) begin errors++; $display("FAIL rstmid_misc got %h exp 0", {busy, done, illegal, k_mux, shamt, mov_hw}); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_hold got %b exp 0", busy); end
    reset_n = 1'b1;
    issue(32'h9100_0C41);
    checks++; if ({fs, stl, c0} !== {5'b01000, 2'b00}) begin errors++; $display("FAIL addi_fs got %b exp 0100000", {fs, stl, c0}); end
    checks++; if ({busy, done, w_reg, pcfs, da} !== {5'b11101, 5'd1}) begin errors++; $display("FAIL addi_bits got %h exp %h", {busy, done, w_reg, pcfs, da}, {5'b11101, 5'd1}); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addi_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_addis_first_start();
    test_movk();
    test_illegal();
    test_width();
    test_logic_math();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
